dsp_mult_acc: RTL and testbench
===============================

Name: dsp_mult_acc

Overview:
- DSP arithmetic stage that consumes the two operands num_1/num_2 produced by the ALU top level and returns dsp_result to it.
- Runs on the 100 MHz clock clk_100 that the ALU top level exports.
- Registered 3-stage pipeline: unsigned 8x8 multiply, plus accumulate, multiply-subtract and hold modes on a 16-bit saturating accumulator.
- Operand-change detection means each new operand pair is accumulated exactly once, although num_1/num_2 are held static for many cycles.

Parameters:
- WIDTH_COUNTER, 8, width of each operand (num_1, num_2).
- WIDTH_MUX, 16, width of product, accumulator and dsp_result; must equal 2*WIDTH_COUNTER.

Ports:
- clk_100  input  1  system clock from ALU top level; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- num_1  input  WIDTH_COUNTER  operand A, unsigned.
- num_2  input  WIDTH_COUNTER  operand B, unsigned.
- mode  input  2  00 multiply, 01 multiply-accumulate, 10 hold, 11 multiply-subtract.
- acc_clr  input  1  synchronous accumulator clear, level-sensitive.
- dsp_result  output  WIDTH_MUX  registered result to ALU top level.
- result_valid  output  1  high once the first result has been written after reset.
- acc_sat  output  1  high while the last accumulate/subtract operation clamped.

Behaviour:
- Interface (already decided): one clock, clk_100; reset is asynchronous and active-high. All flops clear immediately when reset rises. Outputs at reset: dsp_result=0, result_valid=0, acc_sat=0. Internal pipeline, accumulator and change flags are also 0.
- S0 (capture):
  - Register num_1, num_2 and mode into a_q, b_q, mode_q.
  - new_op = (a_q,b_q) differ from the previous captured pair, OR mode_q differs from the previous mode, OR first capture after reset.
  - new_op travels down the pipeline with its data.
- S1 (multiply): prod = a_q*b_q, full 16-bit unsigned, no truncation. Carry mode and new_op alongside.
- S2 (result), in priority order:
  1. acc_clr=1: acc<=0, acc_sat<=0. dsp_result<=0 in modes 01/11; dsp_result<=prod in mode 00; dsp_result unchanged in mode 10.
  2. Mode 00: dsp_result<=prod every cycle; acc unchanged; acc_sat<=0.
  3. Mode 01, new_op=1: sum=acc+prod computed 17 bits wide. If sum>0xFFFF then acc<=0xFFFF and acc_sat<=1, else acc<=sum and acc_sat<=0. dsp_result<=new acc.
  4. Mode 11, new_op=1: if prod>acc then acc<=0 and acc_sat<=1, else acc<=acc-prod and acc_sat<=0. dsp_result<=new acc.
  5. Modes 01/11, new_op=0: acc, dsp_result and acc_sat hold.
  6. Mode 10: all of dsp_result, acc and acc_sat hold. Operand changes in hold are not accumulated later: the flag is consumed in S2 while in hold.
- Latency: an operand/mode change at the input edge appears on dsp_result 3 clk_100 edges later. Throughput is 1 operation per cycle.
- result_valid: set on the first S2 write after reset (3rd edge after reset release) and stays high until reset. An acc_clr does not drop it.
- Mode switches:
  - acc persists across all mode changes.
  - A mode change itself raises new_op, so entering 01 or 11 applies the current product once.
  - Entering 00 shows prod while acc is untouched.
- Simultaneous events: acc_clr together with a new_op in 01/11 means the clear wins and the product is discarded (not added after clearing).
- Reset mid-pipeline: in-flight operations are discarded. After release the first capture counts as new_op.

Test Plan:
- Reset, mode=00, num_1=12, num_2=10 -> dsp_result=0 and result_valid=0 for 2 edges; 3rd edge gives dsp_result=120, result_valid=1.
- Mode 00: change num_1 from 12 to 255 and num_2 to 255 at edge N -> dsp_result=65025 at edge N+3, prior value 120 held through N+2.
- Mode 01, acc_clr pulse, then operand pairs (3,4), (5,6), (5,6) held 10 cycles, then (2,2) -> dsp_result 12, 42, no change while held, then 46; acc_sat=0.
- Mode 01 with acc=65000, apply (200,200) -> dsp_result=0xFFFF, acc_sat=1. Then switch to mode 11 with (10,10) -> dsp_result=65435, acc_sat=0.
- Mode 11 with acc=50, apply (8,8) -> dsp_result=0, acc_sat=1. Mode 10 plus operand changes -> dsp_result frozen for 20 cycles.
- acc_clr asserted on the same cycle as new_op in mode 01 -> dsp_result=0, acc=0. Async reset asserted mid-stream -> all outputs 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/dsp_mult_acc.sv
// -----------------------------------------------------------------------------
// dsp_mult_acc
// Three-stage registered DSP stage for the ALU top level. It multiplies two
// unsigned operands and then, depending on mode, shows the product directly,
// accumulates it, subtracts it from a 16-bit saturating accumulator, or holds.
//
// Pipeline:
//   S0  capture num_1/num_2/mode, flag the pair as new when it differs from
//       the previous capture (or is the first capture after reset)
//   S1  full-width unsigned product, mode and new flag carried alongside
//   S2  accumulator update and registered dsp_result
//
// Because the ALU holds its operands static for many cycles, only captures
// flagged as new are accumulated/subtracted, so each operand pair counts once.
//
// Ports:
//   clk_100       in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   num_1, num_2  in   unsigned operands, WIDTH_COUNTER bits
//   mode          in   00 multiply, 01 mul-acc, 10 hold, 11 mul-sub
//   acc_clr       in   synchronous, level-sensitive accumulator clear (acts in S2)
//   dsp_result    out  registered result, WIDTH_MUX bits
//   result_valid  out  high from the first S2 write after reset
//   acc_sat       out  high while the last accumulate/subtract clamped
//
// WIDTH_MUX must equal 2*WIDTH_COUNTER so the product is never truncated.
// -----------------------------------------------------------------------------
module dsp_mult_acc #(
  parameter int WIDTH_COUNTER = 8,
  parameter int WIDTH_MUX     = 16
) (
  input  logic                     clk_100,
  input  logic                     reset,
  input  logic [WIDTH_COUNTER-1:0] num_1,
  input  logic [WIDTH_COUNTER-1:0] num_2,
  input  logic [1:0]               mode,
  input  logic                     acc_clr,
  output logic [WIDTH_MUX-1:0]     dsp_result,
  output logic                     result_valid,
  output logic                     acc_sat
);

  localparam logic [1:0] MODE_MUL  = 2'b00;
  localparam logic [1:0] MODE_MAC  = 2'b01;
  localparam logic [1:0] MODE_HOLD = 2'b10;
  localparam logic [1:0] MODE_MSU  = 2'b11;

  localparam logic [WIDTH_MUX-1:0] ACC_MAX = '1;

  // ---------------------------------------------------------------- S0
  logic [WIDTH_COUNTER-1:0] a_q, b_q;
  logic [1:0]               mode0_q;
  logic                     new0_q, new0_d;
  logic                     cap_done_q;   // doubles as stage-0 valid

  // Compare the incoming values against the previous capture, which is what
  // a_q/b_q/mode0_q still hold at this edge.
  assign new0_d = ~cap_done_q
                | (num_1 != a_q)
                | (num_2 != b_q)
                | (mode  != mode0_q);

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      mode0_q    <= MODE_MUL;
      new0_q     <= 1'b0;
      cap_done_q <= 1'b0;
    end else begin
      a_q        <= num_1;
      b_q        <= num_2;
      mode0_q    <= mode;
      new0_q     <= new0_d;
      cap_done_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- S1
  logic [WIDTH_MUX-1:0] prod_q, prod_d;
  logic [1:0]           mode1_q;
  logic                 new1_q;
  logic                 vld1_q;

  assign prod_d = WIDTH_MUX'(a_q) * WIDTH_MUX'(b_q);

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      prod_q  <= '0;
      mode1_q <= MODE_MUL;
      new1_q  <= 1'b0;
      vld1_q  <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      mode1_q <= mode0_q;
      new1_q  <= new0_q;
      vld1_q  <= cap_done_q;
    end
  end

  // ---------------------------------------------------------------- S2
  logic [WIDTH_MUX-1:0] acc_q, acc_d;
  logic [WIDTH_MUX-1:0] res_q, res_d;
  logic                 sat_q, sat_d;
  logic                 valid_q;
  logic [WIDTH_MUX:0]   sum;

  // One extra bit so the carry out of acc+prod is the overflow flag.
  assign sum = {1'b0, acc_q} + {1'b0, prod_q};

  always_comb begin
    acc_d = acc_q;
    res_d = res_q;
    sat_d = sat_q;
    if (acc_clr) begin
      // Clear wins over a coinciding new operand; its product is dropped.
      acc_d = '0;
      sat_d = 1'b0;
      case (mode1_q)
        MODE_MUL: res_d = prod_q;
        MODE_MAC,
        MODE_MSU: res_d = '0;
        default:  res_d = res_q;
      endcase
    end else begin
      case (mode1_q)
        MODE_MUL: begin
          res_d = prod_q;
          sat_d = 1'b0;
        end
        MODE_MAC: begin
          if (new1_q) begin
            if (sum[WIDTH_MUX]) begin
              acc_d = ACC_MAX;
              sat_d = 1'b1;
            end else begin
              acc_d = sum[WIDTH_MUX-1:0];
              sat_d = 1'b0;
            end
            res_d = acc_d;
          end
        end
        MODE_MSU: begin
          if (new1_q) begin
            if (prod_q > acc_q) begin
              acc_d = '0;
              sat_d = 1'b1;
            end else begin
              acc_d = acc_q - prod_q;
              sat_d = 1'b0;
            end
            res_d = acc_d;
          end
        end
        // Hold: everything frozen. A new flag arriving here is simply
        // dropped, so operand changes made in hold are never replayed.
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      res_q   <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
      // Sticky until reset; acc_clr does not affect it.
      valid_q <= valid_q | vld1_q;
    end
  end

  assign dsp_result   = res_q;
  assign acc_sat      = sat_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_dsp_mult_acc.sv
module tb_dsp_mult_acc;

  logic        clk_100 = 1'b0;
  logic        reset   = 1'b1;
  logic [7:0]  num_1   = 8'd0;
  logic [7:0]  num_2   = 8'd0;
  logic [1:0]  mode    = 2'b00;
  logic        acc_clr = 1'b0;
  logic [15:0] dsp_result;
  logic        result_valid;
  logic        acc_sat;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_100 = ~clk_100;

  dsp_mult_acc #(.WIDTH_COUNTER(8), .WIDTH_MUX(16)) dut (
    .clk_100      (clk_100),
    .reset        (reset),
    .num_1        (num_1),
    .num_2        (num_2),
    .mode         (mode),
    .acc_clr      (acc_clr),
    .dsp_result   (dsp_result),
    .result_valid (result_valid),
    .acc_sat      (acc_sat)
  );

  // ------------------------------------------------------------------
  // Reference model: a queue of captured operations; each one is acted
  // on two edges after it was captured, using acc_clr present at that edge.
  // ------------------------------------------------------------------
  typedef struct {
    int a;
    int b;
    int m;
    bit nw;
  } op_t;

  op_t pipe[$];
  int  m_acc, m_res;
  bit  m_sat, m_valid;
  bit  have_prev;
  int  pa, pb, pm;

  function automatic void model_reset();
    pipe.delete();
    m_acc = 0; m_res = 0; m_sat = 0; m_valid = 0;
    have_prev = 0; pa = 0; pb = 0; pm = 0;
  endfunction

  function automatic void model_edge(int a, int b, int m, bit clr);
    op_t op, cap;
    int  prod;
    if (pipe.size() == 2) begin
      op   = pipe.pop_front();
      prod = op.a * op.b;
      if (clr) begin
        m_acc = 0;
        m_sat = 0;
        if (op.m == 0) m_res = prod;
        else if (op.m != 2) m_res = 0;
      end else if (op.m == 0) begin
        m_res = prod;
        m_sat = 0;
      end else if (op.m == 1 && op.nw) begin
        if (m_acc + prod > 65535) begin m_acc = 65535; m_sat = 1; end
        else begin m_acc = m_acc + prod; m_sat = 0; end
        m_res = m_acc;
      end else if (op.m == 3 && op.nw) begin
        if (prod > m_acc) begin m_acc = 0; m_sat = 1; end
        else begin m_acc = m_acc - prod; m_sat = 0; end
        m_res = m_acc;
      end
      m_valid = 1;
    end
    cap.a  = a;
    cap.b  = b;
    cap.m  = m;
    cap.nw = !have_prev || a != pa || b != pb || m != pm;
    pipe.push_back(cap);
    have_prev = 1; pa = a; pb = b; pm = m;
  endfunction

  task automatic tick();
    @(posedge clk_100);
    if (!reset) model_edge(int'(num_1), int'(num_2), int'(mode), acc_clr);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(int a, int b, int m);
    num_1 = 8'(a);
    num_2 = 8'(b);
    mode  = 2'(m);
  endtask

  // ------------------------------------------------------------------
  task automatic test_reset();
    model_reset();
    reset = 1'b1;
    drive(12, 10, 0);
    ticks(2);
    n_checks++;
    if (dsp_result !== 16'd0 || result_valid !== 1'b0 || acc_sat !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_hold: got res=%0d valid=%0b sat=%0b want 0/0/0", dsp_result, result_valid, acc_sat);
    end
    reset = 1'b0;
    for (int e = 1; e <= 2; e++) begin
      tick();
      n_checks++;
      if (dsp_result !== 16'd0 || result_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_edge%0d: got res=%0d valid=%0b want 0/0", e, dsp_result, result_valid);
      end
    end
    tick();
    n_checks++;
    if (dsp_result !== 16'd120 || result_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_first_result: got res=%0d valid=%0b want 120/1", dsp_result, result_valid);
    end
  endtask

  task automatic test_mode00();
    drive(255, 255, 0);
    for (int e = 1; e <= 2; e++) begin
      tick();
      n_checks++;
      if (dsp_result !== 16'd120) begin
        n_errors++;
        $display("FAIL mul_latency_edge%0d: got %0d want 120", e, dsp_result);
      end
    end
    tick();
    n_checks++;
    if (dsp_result !== 16'd65025) begin
      n_errors++;
      $display("FAIL mul_255x255: got %0d want 65025", dsp_result);
    end
  endtask

  task automatic test_mac();
    mode = 2'b01;
    acc_clr = 1'b1;
    ticks(4);
    acc_clr = 1'b0;
    n_checks++;
    if (dsp_result !== 16'd0) begin
      n_errors++;
      $display("FAIL mac_clear: got %0d want 0", dsp_result);
    end
    drive(3, 4, 1);
    ticks(3);
    n_checks++;
    if (dsp_result !== 16'd12 || acc_sat !== 1'b0) begin
      n_errors++;
      $display("FAIL mac_3x4: got res=%0d sat=%0b want 12/0", dsp_result, acc_sat);
    end
    drive(5, 6, 1);
    ticks(3);
    n_checks++;
    if (dsp_result !== 16'd42) begin
      n_errors++;
      $display("FAIL mac_5x6: got %0d want 42", dsp_result);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (dsp_result !== 16'd42 || acc_sat !== 1'b0) begin
        n_errors++;
        $display("FAIL mac_held cycle %0d: got res=%0d sat=%0b want 42/0", i, dsp_result, acc_sat);
      end
    end
    drive(2, 2, 1);
    ticks(3);
    n_checks++;
    if (dsp_result !== 16'd46 || acc_sat !== 1'b0) begin
      n_errors++;
      $display("FAIL mac_2x2: got res=%0d sat=%0b want 46/0", dsp_result, acc_sat);
    end
  endtask

  task automatic test_sat();
    acc_clr = 1'b1;
    ticks(3);
    acc_clr = 1'b0;
    drive(250, 250, 1);
    ticks(3);
    drive(50, 50, 1);
    ticks(3);
    n_checks++;
    if (dsp_result !== 16'd65000) begin
      n_errors++;
      $display("FAIL sat_setup: got %0d want 65000", dsp_result);
    end
    drive(200, 200, 1);
    ticks(3);
    n_checks++;
    if (dsp_result !== 16'hFFFF || acc_sat !== 1'b1) begin
      n_errors++;
      $display("FAIL mac_saturate: got res=%0d sat=%0b want 65535/1", dsp_result, acc_sat);
    end
    drive(10, 10, 3);
    ticks(3);
    n_checks++;
    if (dsp_result !== 16'd65435 || acc_sat !== 1'b0) begin
      n_errors++;
      $display("FAIL msu_after_sat: got res=%0d sat=%0b want 65435/0", dsp_result, acc_sat);
    end
  endtask

  task automatic test_sub_hold();
    acc_clr = 1'b1;
    ticks(3);
    acc_clr = 1'b0;
    drive(5, 10, 1);
    ticks(3);
    n_checks++;
    if (dsp_result !== 16'd50) begin
      n_errors++;
      $display("FAIL sub_setup: got %0d want 50", dsp_result);
    end
    drive(8, 8, 3);
    ticks(3);
    n_checks++;
    if (dsp_result !== 16'd0 || acc_sat !== 1'b1) begin
      n_errors++;
      $display("FAIL msu_underflow: got res=%0d sat=%0b want 0/1", dsp_result, acc_sat);
    end
    for (int i = 0; i < 20; i++) begin
      drive(int'($urandom_range(1, 255)), int'($urandom_range(1, 255)), 2);
      tick();
      n_checks++;
      if (dsp_result !== 16'd0 || acc_sat !== 1'b1) begin
        n_errors++;
        $display("FAIL hold_frozen cycle %0d: got res=%0d sat=%0b want 0/1", i, dsp_result, acc_sat);
      end
    end
  endtask

  task automatic test_clr_collision();
    drive(3, 3, 1);
    ticks(3);
    n_checks++;
    if (dsp_result !== 16'd9) begin
      n_errors++;
      $display("FAIL collision_setup: got %0d want 9", dsp_result);
    end
    drive(7, 9, 1);
    ticks(2);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    n_checks++;
    if (dsp_result !== 16'd0 || acc_sat !== 1'b0) begin
      n_errors++;
      $display("FAIL clr_collision: got res=%0d sat=%0b want 0/0", dsp_result, acc_sat);
    end
    ticks(4);
    n_checks++;
    if (dsp_result !== 16'd0) begin
      n_errors++;
      $display("FAIL clr_discard: got %0d want 0", dsp_result);
    end
  endtask

  task automatic test_random();
    int hold_left;
    hold_left = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold_left == 0) begin
        hold_left = int'($urandom_range(1, 5));
        if ($urandom_range(0, 1) == 0)
          drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        else
          drive(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
      hold_left--;
      acc_clr = ($urandom_range(0, 15) == 0);
      tick();
      n_checks++;
      if (dsp_result !== 16'(m_res) || acc_sat !== m_sat || result_valid !== m_valid) begin
        n_errors++;
        $display("FAIL random cycle %0d: got res=%0d sat=%0b valid=%0b want %0d/%0b/%0b",
                 i, dsp_result, acc_sat, result_valid, m_res, m_sat, m_valid);
      end
    end
    acc_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    drive(100, 200, 1);
    tick();
    drive(9, 9, 0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (dsp_result !== 16'd0 || result_valid !== 1'b0 || acc_sat !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: got res=%0d valid=%0b sat=%0b want 0/0/0", dsp_result, result_valid, acc_sat);
    end
    ticks(2);
    reset = 1'b0;
    drive(6, 7, 0);
    ticks(2);
    n_checks++;
    if (dsp_result !== 16'd0 || result_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset_flush: got res=%0d valid=%0b want 0/0", dsp_result, result_valid);
    end
    tick();
    n_checks++;
    if (dsp_result !== 16'd42 || result_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL post_reset_first: got res=%0d valid=%0b want 42/1", dsp_result, result_valid);
    end
    // Accumulator must restart from zero after reset.
    drive(6, 7, 1);
    ticks(3);
    n_checks++;
    if (dsp_result !== 16'd42 || dsp_result !== 16'(m_res)) begin
      n_errors++;
      $display("FAIL post_reset_acc: got %0d want 42", dsp_result);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mode00();
    test_mac();
    test_sat();
    test_sub_hold();
    test_clr_collision();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
